// File: rtl/rv32_pkg.sv
// Shared encodings for the multi-cycle RV32I core: FSM states, ALUOp codes,
// opcodes and datapath mux selects used by the control FSM and alu_control.
package rv32_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_LUI     = 4'd4,
    S_ADDR    = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_WB_ALU  = 4'd8,
    S_WB_MEM  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JAL     = 4'd11,
    S_JALR    = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_RS1  = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // AUIPC skips execute because DECODE already left pc_old+imm in ALUOut;
  // FENCE retires straight out of DECODE and is therefore handled by the caller.
  function automatic state_t decode_target(input logic [6:0] op);
    case (op)
      OP_RTYPE:           decode_target = S_EXEC_R;
      OP_ITYPE:           decode_target = S_EXEC_I;
      OP_LOAD, OP_STORE:  decode_target = S_ADDR;
      OP_BRANCH:          decode_target = S_BRANCH;
      OP_JAL:             decode_target = S_JAL;
      OP_JALR:            decode_target = S_JALR;
      OP_LUI:             decode_target = S_LUI;
      OP_AUIPC:           decode_target = S_WB_ALU;
      OP_FENCE:           decode_target = S_FETCH;
      default:            decode_target = S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, stalling on the mem_req/mem_ready handshake.
module multicycle_control
  import rv32_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic [1:0] ALUOp,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       instr_retired,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = decode_target(opcode);
      S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_WB_ALU;
      S_ADDR:   state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Everything is forced low while rst is high so an aborted instruction
  // can neither write state nor keep a memory request alive.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    ALUOp         = ALUOP_ADD;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    reg_write     = 1'b0;
    wb_sel        = WB_ALUOUT;
    instr_retired = 1'b0;
    illegal       = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b     = SRC_B_IMM;
          instr_retired = (opcode == OP_FENCE);
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          ALUOp     = ALUOP_RTYPE;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          ALUOp     = ALUOP_ITYPE;
        end
        S_LUI: begin
          alu_src_a = SRC_A_ZERO;
          alu_src_b = SRC_B_IMM;
        end
        S_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req       = 1'b1;
          mem_we        = 1'b1;
          iord          = 1'b1;
          instr_retired = mem_ready;
        end
        S_WB_ALU: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_WB_MEM: begin
          reg_write     = 1'b1;
          wb_sel        = WB_MDR;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = SRC_A_RS1;
          ALUOp         = ALUOP_BRANCH;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          instr_retired = 1'b1;
        end
        S_JAL: begin
          pc_write      = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          reg_write     = 1'b1;
          wb_sel        = WB_PC;
          instr_retired = 1'b1;
        end
        S_JALR: begin
          alu_src_a     = SRC_A_RS1;
          alu_src_b     = SRC_B_IMM;
          pc_write      = 1'b1;
          pc_source     = PCSRC_JALR;
          reg_write     = 1'b1;
          wb_sel        = WB_PC;
          instr_retired = 1'b1;
        end
        S_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven check of multicycle_control: per-cycle vectors of inputs and
// hand-computed outputs, plus latency sequences with memory wait states.
module tb_multicycle_control;
  import rv32_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, ALUOp, alu_src_a, alu_src_b, wb_sel;
  logic       reg_write, instr_retired, illegal;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .wb_sel(wb_sel), .instr_retired(instr_retired),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;
  localparam logic [6:0] FN = 7'b0001111, SY = 7'b1110011;

  // Bit order: req we iord irw pcw pcwc pcs aop sa sb rw wbs ret ill
  localparam logic [18:0] E_ZERO   = 19'b0_0_0_0_0_0_00_00_00_00_0_00_0_0;
  localparam logic [18:0] E_FWAIT  = 19'b1_0_0_0_0_0_00_00_00_01_0_00_0_0;
  localparam logic [18:0] E_FGO    = 19'b1_0_0_1_1_0_00_00_00_01_0_00_0_0;
  localparam logic [18:0] E_DEC    = 19'b0_0_0_0_0_0_00_00_00_10_0_00_0_0;
  localparam logic [18:0] E_DECFN  = 19'b0_0_0_0_0_0_00_00_00_10_0_00_1_0;
  localparam logic [18:0] E_EXR    = 19'b0_0_0_0_0_0_00_10_01_00_0_00_0_0;
  localparam logic [18:0] E_EXI    = 19'b0_0_0_0_0_0_00_11_01_10_0_00_0_0;
  localparam logic [18:0] E_LUI    = 19'b0_0_0_0_0_0_00_00_10_10_0_00_0_0;
  localparam logic [18:0] E_ADDR   = 19'b0_0_0_0_0_0_00_00_01_10_0_00_0_0;
  localparam logic [18:0] E_MRD    = 19'b1_0_1_0_0_0_00_00_00_00_0_00_0_0;
  localparam logic [18:0] E_MWR    = 19'b1_1_1_0_0_0_00_00_00_00_0_00_0_0;
  localparam logic [18:0] E_MWRGO  = 19'b1_1_1_0_0_0_00_00_00_00_0_00_1_0;
  localparam logic [18:0] E_WBA    = 19'b0_0_0_0_0_0_00_00_00_00_1_00_1_0;
  localparam logic [18:0] E_WBM    = 19'b0_0_0_0_0_0_00_00_00_00_1_01_1_0;
  localparam logic [18:0] E_BR     = 19'b0_0_0_0_0_1_01_01_01_00_0_00_1_0;
  localparam logic [18:0] E_JAL    = 19'b0_0_0_0_1_0_01_00_00_00_1_10_1_0;
  localparam logic [18:0] E_JALR   = 19'b0_0_0_0_1_0_10_00_01_10_1_10_1_0;
  localparam logic [18:0] E_TRAP   = 19'b0_0_0_0_0_0_00_00_00_00_0_00_0_1;

  typedef struct {
    logic        rst;
    logic [6:0]  opc;
    logic        rdy;
    state_t      st;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [6:0] o, input logic y,
                     input state_t s, input logic [18:0] e);
    vec_t v;
    v.rst = r; v.opc = o; v.rdy = y; v.st = s; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    opcode = v.opc;
    mem_ready = v.rdy;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    logic [18:0] act;
    act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
           ALUOp, alu_src_a, alu_src_b, reg_write, wb_sel, instr_retired, illegal};
    checks++;
    if (state !== 4'(v.st)) begin
      errors++;
      $display("[TB] FAIL state row %0d: got %0d expected %0d", idx, state, v.st);
    end
    checks++;
    if (act !== v.exp) begin
      errors++;
      $display("[TB] FAIL outputs row %0d: got %b expected %b", idx, act, v.exp);
    end
  endtask

  // Runs one instruction from FETCH, holding mem_ready low for w cycles on
  // every memory request, and checks the cycle count up to its retire pulse.
  task automatic measureLatency(input string name, input logic [6:0] o,
                                input int w, input int expected);
    int cycles = 0;
    int left = w;
    bit done = 0;
    rst = 1'b0;
    opcode = o;
    while (!done && cycles < 50) begin
      mem_ready = 1'b0;
      if (mem_req) begin
        if (left > 0) left--;
        else begin
          mem_ready = 1'b1;
          left = w;
        end
      end
      @(negedge clk);
      cycles++;
      if (instr_retired) done = 1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done || cycles != expected) begin
      errors++;
      $display("[TB] FAIL latency %s: got %0d cycles (retired=%0d) expected %0d",
               name, cycles, done, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode = 7'd0;
    mem_ready = 1'b0;

    add(1, R, 0, S_FETCH, E_ZERO);
    add(1, R, 1, S_FETCH, E_ZERO);
    // ADD, zero-wait
    add(0, R, 1, S_FETCH, E_FGO);  add(0, R, 1, S_DECODE, E_DEC);
    add(0, R, 1, S_EXEC_R, E_EXR); add(0, R, 1, S_WB_ALU, E_WBA);
    // ADDI with one fetch wait; mem_ready ignored outside requests
    add(0, I, 0, S_FETCH, E_FWAIT); add(0, I, 1, S_FETCH, E_FGO);
    add(0, I, 1, S_DECODE, E_DEC);  add(0, I, 1, S_EXEC_I, E_EXI);
    add(0, I, 1, S_WB_ALU, E_WBA);
    // LW with three MEM_RD wait cycles: 8 cycles total
    add(0, LD, 1, S_FETCH, E_FGO);  add(0, LD, 0, S_DECODE, E_DEC);
    add(0, LD, 0, S_ADDR, E_ADDR);  add(0, LD, 0, S_MEM_RD, E_MRD);
    add(0, LD, 0, S_MEM_RD, E_MRD); add(0, LD, 0, S_MEM_RD, E_MRD);
    add(0, LD, 1, S_MEM_RD, E_MRD); add(0, LD, 0, S_WB_MEM, E_WBM);
    // SW zero-wait
    add(0, ST, 1, S_FETCH, E_FGO);  add(0, ST, 1, S_DECODE, E_DEC);
    add(0, ST, 1, S_ADDR, E_ADDR);  add(0, ST, 1, S_MEM_WR, E_MWRGO);
    // BEQ, JAL, JALR
    add(0, BR, 1, S_FETCH, E_FGO);  add(0, BR, 1, S_DECODE, E_DEC);
    add(0, BR, 1, S_BRANCH, E_BR);
    add(0, JL, 1, S_FETCH, E_FGO);  add(0, JL, 1, S_DECODE, E_DEC);
    add(0, JL, 1, S_JAL, E_JAL);
    add(0, JR, 1, S_FETCH, E_FGO);  add(0, JR, 1, S_DECODE, E_DEC);
    add(0, JR, 1, S_JALR, E_JALR);
    // LUI, AUIPC, FENCE
    add(0, LU, 1, S_FETCH, E_FGO);  add(0, LU, 1, S_DECODE, E_DEC);
    add(0, LU, 1, S_LUI, E_LUI);    add(0, LU, 1, S_WB_ALU, E_WBA);
    add(0, AU, 1, S_FETCH, E_FGO);  add(0, AU, 1, S_DECODE, E_DEC);
    add(0, AU, 1, S_WB_ALU, E_WBA);
    add(0, FN, 1, S_FETCH, E_FGO);  add(0, FN, 1, S_DECODE, E_DECFN);
    // Reset during the MEM_WR wait aborts the store without a retire
    add(0, ST, 1, S_FETCH, E_FGO);  add(0, ST, 0, S_DECODE, E_DEC);
    add(0, ST, 0, S_ADDR, E_ADDR);  add(0, ST, 0, S_MEM_WR, E_MWR);
    add(1, ST, 1, S_FETCH, E_ZERO); add(0, R, 0, S_FETCH, E_FWAIT);
    // SYSTEM traps and holds until reset
    add(0, SY, 1, S_FETCH, E_FGO);  add(0, SY, 1, S_DECODE, E_DEC);
    for (int k = 0; k < 10; k++) add(0, SY, k[0], S_TRAP, E_TRAP);
    add(1, SY, 0, S_FETCH, E_ZERO); add(0, R, 0, S_FETCH, E_FWAIT);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    measureLatency("sw_w2", ST, 2, 8);
    measureLatency("jalr_w2", JR, 2, 5);
    measureLatency("lw_w1", LD, 1, 7);
    measureLatency("add_w0", R, 0, 4);
    measureLatency("fence_w3", FN, 3, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle RV32I core. It sequences the shared ALU, the register file, the PC and the memory port across fetch, decode, execute, memory and writeback. It drives `ALUOp` into `alu_control` plus all datapath mux selects and write enables. It sits between the instruction register's opcode field and the datapath, and stalls on a req/ready memory handshake.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous, active-high reset
- `opcode` in 7: IR[6:0], valid from DECODE onward
- `mem_ready` in 1: memory completes the current request this cycle
- `mem_req` out 1: memory request
- `mem_we` out 1: the request is a write
- `iord` out 1: address select, 0=PC, 1=ALUOut
- `ir_write` out 1: latch IR and pc_old
- `pc_write` out 1: unconditional PC write
- `pc_write_cond` out 1: PC write gated externally by branch compare
- `pc_source` out 2: 0=ALU result, 1=ALUOut, 2=ALU result with bit0 cleared
- `ALUOp` out 2: 00 add, 01 branch, 10 R-type, 11 I-type
- `alu_src_a` out 2: 0=pc_old, 1=rs1 (A reg), 2=zero
- `alu_src_b` out 2: 0=rs2 (B reg), 1=const 4, 2=immediate
- `reg_write` out 1: register file write
- `wb_sel` out 2: 0=ALUOut, 1=MDR, 2=PC
- `instr_retired` out 1: 1-cycle pulse in each instruction's final cycle
- `illegal` out 1: sticky illegal-opcode flag
- `state` out 4: current state, for debug

## Operation
- Moore FSM. All outputs are decoded from the state register only, except `mem_req` handshake completion. Unlisted outputs are 0.
- **FETCH**
  - Drives mem_req=1, iord=0, src_a=0 (PC via pc_old path = PC), src_b=1, ALUOp=00, pc_source=0.
  - On mem_ready it also asserts ir_write=1 and pc_write=1, then goes to DECODE. Otherwise it stays.
- **DECODE**
  - Drives src_a=0, src_b=2, ALUOp=00, so ALUOut = pc_old+imm.
  - Branches on opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 / 0100011 → ADDR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → WB_ALU (AUIPC; ALUOut already valid)
    - 0001111 → FETCH with retire (FENCE as NOP)
    - anything else → TRAP
- **EXEC_R**: src_a=1, src_b=0, ALUOp=10 → WB_ALU.
- **EXEC_I**: src_a=1, src_b=2, ALUOp=11 → WB_ALU.
- **LUI**: src_a=2, src_b=2, ALUOp=00 → WB_ALU.
- **ADDR**: src_a=1, src_b=2, ALUOp=00. Goes to MEM_RD for a load, MEM_WR for a store.
- **MEM_RD**: mem_req=1, iord=1. On mem_ready → WB_MEM.
- **MEM_WR**: mem_req=1, mem_we=1, iord=1. On mem_ready → FETCH with retire.
- **WB_ALU**: reg_write=1, wb_sel=0, retire → FETCH.
- **WB_MEM**: reg_write=1, wb_sel=1, retire → FETCH.
- **BRANCH**: src_a=1, src_b=0, ALUOp=01, pc_write_cond=1, pc_source=1, retire → FETCH.
- **JAL**: pc_write=1, pc_source=1, reg_write=1, wb_sel=2, retire → FETCH. rd receives the pre-update PC, which is pc_old+4.
- **JALR**: src_a=1, src_b=2, ALUOp=00, pc_write=1, pc_source=2, reg_write=1, wb_sel=2, retire → FETCH.
- **TRAP**: illegal=1, all enables 0. Stays in TRAP until rst.

## Timing
- Reset:
  - Next edge with rst=1 puts the FSM in FETCH and clears illegal.
  - During reset every output is 0, including mem_req. The state register does not drive outputs while rst is high.
- Reset mid-operation (any state, including a pending memory wait) aborts the instruction.
  - No write enable is asserted in the reset cycle.
  - mem_req drops the same cycle.
- Handshake:
  - mem_req, mem_we and iord stay constant until the cycle where mem_ready=1.
  - mem_ready is ignored when mem_req=0.
- Latency with zero-wait memory (mem_ready=1 in the first request cycle):
  - R/I/LUI/AUIPC: 4 cycles (AUIPC: 3)
  - load: 5 cycles
  - store: 4 cycles
  - branch, JAL, JALR: 3 cycles
  - FENCE: 2 cycles
  - Each memory wait cycle adds 1.
- Memory waits per instruction are unbounded, and no timeout is applied.
- instr_retired is asserted in exactly one cycle per completed instruction. It is never asserted in TRAP.

## Structure
- Shared package `rv32_pkg` holds:
  - the state enum (4 bits)
  - the ALUOp encodings
  - the opcode constants
  - the src_a, src_b, pc_source and wb_sel encodings
- `alu_control` consumes the ALUOp encodings from the same package.
- Single module with no sub-modules: a state register plus a combinational next-state/output decoder.

## Test plan
- ADD (opcode 0110011), mem_ready tied 1:
  - states go FETCH→DECODE→EXEC_R→WB_ALU→FETCH
  - ALUOp=10 in EXEC_R
  - reg_write in cycle 4, instr_retired exactly once
- LW with mem_ready low for 3 cycles in MEM_RD:
  - FSM holds MEM_RD with mem_req=1 and iord=1 stable
  - WB_MEM follows the ready cycle; total latency is 8 cycles
- BEQ (1100011):
  - BRANCH state shows ALUOp=01, pc_write_cond=1, pc_source=1
  - pc_write=0 and reg_write=0
- JALR:
  - pc_source=2, pc_write=1, reg_write=1, wb_sel=2 in the same cycle
  - 3-cycle latency
- Opcode 1110011 (SYSTEM):
  - DECODE goes to TRAP, illegal=1 and held for 10 cycles
  - rst=1 for one cycle returns to FETCH with illegal=0
- Reset asserted in the MEM_WR wait cycle:
  - mem_req and mem_we are 0 in that cycle
  - state is FETCH on the next edge, and no instr_retired pulse occurs
